// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - round-robin scheduler sharing one programmable delay counter
// Optional abort port pair enabled by DELAY_SCHED_ABORT_EN.
module delay_sched #(
   parameter int NREQ      = 4,
   parameter int CBITS     = 15,
   parameter int DEFAULT_N = 25000,
   localparam int IW       = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             cfg_we,
   input  logic [CBITS-1:0] cfg_val,
`ifdef DELAY_SCHED_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic [NREQ-1:0]  grant,
   output logic             busy,
   output logic             done,
   output logic [IW-1:0]    done_id,
   output logic [CBITS-1:0] cnt,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t           state_q;
   logic [NREQ-1:0]  grant_q;
   logic             busy_q, done_q, err_q;
   logic [IW-1:0]    done_id_q, rr_q;
   logic [CBITS-1:0] cnt_q, lim_q, run_lim_q;
   logic [CBITS-1:0] cnt_d;
   logic [IW-1:0]    sel, idx;
   logic             found, err_d;
`ifdef DELAY_SCHED_ABORT_EN
   logic             aborted_q;
   assign aborted = aborted_q;
`endif

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign cnt     = cnt_q;
   assign err     = err_q;
   assign cnt_d   = cnt_q + CBITS'(1);

   // First requester above the last winner, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(rr_q) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // done_q marks cnt==run_lim, so an all-ones count without done would wrap.
   assign err_d = (state_q == RUN) &&
                  ((cnt_q > run_lim_q) || (!done_q && (cnt_q == '1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         lim_q     <= CBITS'(DEFAULT_N);
         run_lim_q <= '0;
         rr_q      <= IW'(NREQ - 1);
`ifdef DELAY_SCHED_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef DELAY_SCHED_ABORT_EN
         aborted_q <= 1'b0;
`endif
         if (cfg_we) lim_q <= cfg_val;
         err_q <= err_q | err_d;
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q   <= RUN;
                  grant_q   <= NREQ'(1) << sel;
                  rr_q      <= sel;
                  done_id_q <= sel;
                  cnt_q     <= '0;
                  run_lim_q <= lim_q;
                  busy_q    <= 1'b1;
                  done_q    <= (lim_q == '0);
               end
            end
            RUN: begin
               if (done_q) begin
                  state_q <= GAP;
                  grant_q <= '0;
                  cnt_q   <= '0;
               end
`ifdef DELAY_SCHED_ABORT_EN
               else if (abort && (cnt_q < run_lim_q)) begin
                  state_q   <= GAP;
                  grant_q   <= '0;
                  cnt_q     <= '0;
                  aborted_q <= 1'b1;
               end
`endif
               else begin
                  cnt_q  <= cnt_d;
                  done_q <= (cnt_d == run_lim_q);
               end
            end
            GAP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - directed vector bench for delay_sched
module tb_delay_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic        cfg_we = 1'b0;
   logic [14:0] cfg_val = '0;
   logic [3:0]  grant;
   logic        busy, done, err;
   logic [1:0]  done_id;
   logic [14:0] cnt;
`ifdef DELAY_SCHED_ABORT_EN
   logic        abort = 1'b0;
   logic        aborted;
`endif

   int n_chk = 0;
   int n_pass = 0;

   delay_sched #(.NREQ(4), .CBITS(15), .DEFAULT_N(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cfg_we(cfg_we), .cfg_val(cfg_val),
`ifdef DELAY_SCHED_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .grant(grant), .busy(busy), .done(done), .done_id(done_id),
      .cnt(cnt), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  g;
      logic        busy;
      logic        done;
      logic [1:0]  id;
      logic [14:0] cnt;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic cfg_step(input logic [14:0] v, input logic [3:0] r);
      cfg_we  = 1'b1;
      cfg_val = v;
      step(r);
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      #10;
      rst_n = 1'b1;
   endtask

   task automatic chk_run(input string tag, input logic [3:0] g, input logic [14:0] c,
                          input logic d, input logic [1:0] id);
      chk({tag, " grant"}, 32'(grant), 32'(g));
      chk({tag, " cnt"}, 32'(cnt), 32'(c));
      chk({tag, " done"}, 32'(done), 32'(d));
      if (d) chk({tag, " done_id"}, 32'(done_id), 32'(id));
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd0};
      tbl[1]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd1};
      tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd2};
      tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd3};
      tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd4};
      tbl[5]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 15'd5};
      tbl[6]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 15'd0};
      tbl[7]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 15'd0};
      tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd0};
      tbl[9]  = '{4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd1};
      tbl[10] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd2};
      tbl[11] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd3};
      tbl[12] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 15'd4};
      tbl[13] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 15'd5};
      tbl[14] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 15'd0};
      tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 15'd0};
      tbl[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 15'd0};

      // Reset state
      #12;
      chk("rst grant", 32'(grant), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst done_id", 32'(done_id), 0);
      chk("rst cnt", 32'(cnt), 0);
      chk("rst err", 32'(err), 0);
      rst_n = 1'b1;

      // Single requester, default limit 5, then req dropped mid-run
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].req);
         chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].done));
         chk($sformatf("vec%0d cnt", i), 32'(cnt), 32'(tbl[i].cnt));
         if (tbl[i].done) chk($sformatf("vec%0d done_id", i), 32'(done_id), 32'(tbl[i].id));
      end

      // Round robin, limit 3, all requesting
      do_reset();
      cfg_step(15'd3, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            step(4'b1111);
            chk_run($sformatf("rr%0d.%0d", k, c), 4'(1 << (k % 4)), 15'(c), c == 3, 2'(k % 4));
         end
         if (k < 4) begin
            step(4'b1111);
            chk($sformatf("rr%0d gap", k), 32'(grant), 0);
            step(4'b1111);
            chk($sformatf("rr%0d idle", k), 32'(grant), 0);
         end
      end
      chk("rr err", 32'(err), 0);

      // Limit write during a run affects only the next grant
      do_reset();
      step(4'b0001);
      chk_run("wr0", 4'b0001, 15'd0, 1'b0, 2'd0);
      cfg_step(15'd0, 4'b0001);
      for (int c = 2; c <= 5; c++) begin
         step(4'b0001);
         chk_run($sformatf("wr%0d", c), 4'b0001, 15'(c), c == 5, 2'd0);
      end
      step(4'b0001);
      step(4'b0001);
      step(4'b0001);
      chk_run("wr lim0", 4'b0001, 15'd0, 1'b1, 2'd0);
      step(4'b0001);
      chk("wr lim0 end grant", 32'(grant), 0);
      chk("wr lim0 end done", 32'(done), 0);

      // Asynchronous reset mid-run
      do_reset();
      step(4'b0001);
      step(4'b0001);
      step(4'b0001);
      chk("pre-arst cnt", 32'(cnt), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst grant", 32'(grant), 0);
      chk("arst busy", 32'(busy), 0);
      chk("arst cnt", 32'(cnt), 0);
      chk("arst done", 32'(done), 0);
      #10;
      rst_n = 1'b1;
      step(4'b1111);
      chk("arst regrant", 32'(grant), 32'(4'b0001));

      // Granted requester drops req mid-run
      do_reset();
      cfg_step(15'd4, 4'b0000);
      step(4'b0100);
      chk_run("drop0", 4'b0100, 15'd0, 1'b0, 2'd0);
      step(4'b0100);
      step(4'b1011);
      step(4'b1011);
      step(4'b1011);
      chk_run("drop done", 4'b0100, 15'd4, 1'b1, 2'd2);
      step(4'b1011);
      step(4'b1011);
      step(4'b1011);
      chk("drop next grant", 32'(grant), 32'(4'b1000));
      chk("drop err", 32'(err), 0);

`ifdef DELAY_SCHED_ABORT_EN
      do_reset();
      cfg_step(15'd10, 4'b0000);
      for (int c = 0; c < 4; c++) step(4'b0011);
      chk("ab cnt", 32'(cnt), 3);
      abort = 1'b1;
      step(4'b0011);
      abort = 1'b0;
      chk("ab aborted", 32'(aborted), 1);
      chk("ab done", 32'(done), 0);
      chk("ab grant", 32'(grant), 0);
      step(4'b0011);
      chk("ab aborted2", 32'(aborted), 0);
      chk("ab grant2", 32'(grant), 0);
      step(4'b0011);
      chk("ab next grant", 32'(grant), 32'(4'b0010));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
